// File: rtl/ao_mon_pkg.sv
// Shared definitions for the AND-OR settle-time monitor.
//   - default parameter values
//   - monitor FSM state encoding
//   - ao_gold(): reference AND-OR, w = (&stim[in_w-1:1]) | stim[0]
package ao_mon_pkg;

  localparam int AO_IN_W    = 3;
  localparam int AO_NUM_CH  = 2;
  localparam int AO_CNT_W   = 8;
  localparam int AO_TIMEOUT = 63;
  localparam int AO_HOLD    = 4;
  localparam int AO_MAX_W   = 32;  // widest stimulus ao_gold() accepts

  typedef enum logic [1:0] {IDLE, MEAS, REPORT} ao_state_e;

  // Stimulus is zero-extended to AO_MAX_W; bits at or above in_w are ignored.
  function automatic logic ao_gold(input logic [AO_MAX_W-1:0] stim,
                                   input int unsigned          in_w);
    logic a;
    a = 1'b1;
    for (int i = 1; i < AO_MAX_W; i++)
      if (i < in_w) a = a & stim[i];
    return a | stim[0];
  endfunction

endpackage

// File: rtl/ao_settle_chan.sv
// Per-channel settle tracking for ao_settle_monitor.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        new measurement (start or abort): clears settled flag
//   meas_i         live measurement cycle (not being aborted)
//   match_i        channel output equals golden value this cycle
//   timeout_i      measurement closes by timeout this cycle
//   cnt_i          current settle counter
//   settle_nxt_o   next settle value (only with AO_SETTLE_DELTA_EN)
//   settle_o       latched settle cycles
//   timeout_err_o  sticky: channel never settled before timeout
//   glitch_err_o   sticky: channel lost a match inside one measurement
module ao_settle_chan
  import ao_mon_pkg::*;
#(
  parameter int CNT_W   = AO_CNT_W,
  parameter int TIMEOUT = AO_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             meas_i,
  input  logic             match_i,
  input  logic             timeout_i,
  input  logic [CNT_W-1:0] cnt_i,
`ifdef AO_SETTLE_DELTA_EN
  output logic [CNT_W-1:0] settle_nxt_o,
`endif
  output logic [CNT_W-1:0] settle_o,
  output logic             timeout_err_o,
  output logic             glitch_err_o
);

  logic             settled_q, settled_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic             to_q, to_d;
  logic             gl_q, gl_d;

  always_comb begin
    settled_d = settled_q;
    settle_d  = settle_q;
    to_d      = to_q;
    gl_d      = gl_q;
    if (start_i) begin
      settled_d = 1'b0;
    end else if (meas_i) begin
      if (match_i && !settled_q) begin
        settled_d = 1'b1;
        settle_d  = cnt_i;
      end else if (!match_i && settled_q) begin
        // Lost the match: re-arm so the next match re-latches settle.
        settled_d = 1'b0;
        gl_d      = 1'b1;
      end
      // A channel matching in the timeout cycle counts as settled.
      if (timeout_i && !match_i) begin
        settle_d = CNT_W'(TIMEOUT);
        to_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      settled_q <= 1'b0;
      settle_q  <= '0;
      to_q      <= 1'b0;
      gl_q      <= 1'b0;
    end else begin
      settled_q <= settled_d;
      settle_q  <= settle_d;
      to_q      <= to_d;
      gl_q      <= gl_d;
    end
  end

  assign settle_o      = settle_q;
  assign timeout_err_o = to_q;
  assign glitch_err_o  = gl_q;
`ifdef AO_SETTLE_DELTA_EN
  assign settle_nxt_o  = settle_d;
`endif

endmodule

// File: rtl/ao_settle_monitor.sv
// Settle-time monitor for NUM_CH implementations of the AND-OR function.
// Every stimulus change starts a measurement; per-channel settle cycles are
// reported with a one-cycle meas_valid once all channels matched for HOLD
// consecutive cycles, or when the counter reaches TIMEOUT.
// Optional: AO_SETTLE_DELTA_EN adds output delta = |settle[i] - settle[0]|.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stim          stimulus applied to all channels
//   ch_out        output bit of each implementation
//   busy          measurement in progress
//   meas_valid    one-cycle report pulse, settle fields valid with it
//   settle        per-channel settle cycles, ch i at [i*CNT_W +: CNT_W]
//   timeout_err   sticky per-channel timeout
//   glitch_err    sticky per-channel glitch
//   abort_cnt     saturating count of aborted measurements
//   delta         (AO_SETTLE_DELTA_EN only) per-channel |settle - settle[0]|
module ao_settle_monitor
  import ao_mon_pkg::*;
#(
  parameter int IN_W    = AO_IN_W,
  parameter int NUM_CH  = AO_NUM_CH,
  parameter int CNT_W   = AO_CNT_W,
  parameter int TIMEOUT = AO_TIMEOUT,
  parameter int HOLD    = AO_HOLD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         stim,
  input  logic [NUM_CH-1:0]       ch_out,
  output logic                    busy,
  output logic                    meas_valid,
  output logic [NUM_CH*CNT_W-1:0] settle,
  output logic [NUM_CH-1:0]       timeout_err,
  output logic [NUM_CH-1:0]       glitch_err,
  output logic [CNT_W-1:0]        abort_cnt
`ifdef AO_SETTLE_DELTA_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] delta
`endif
);

  localparam int RUN_W = $clog2(HOLD + 1);

  ao_state_e   state_q, state_d;
  logic [IN_W-1:0]  stim_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RUN_W-1:0] run_q;
  logic [CNT_W-1:0] abort_q;

  logic              gold, stim_chg, all_match, hold_done, cnt_to;
  logic              start, meas_ok, to_fire;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0][CNT_W-1:0] settle_w;

  assign gold      = ao_gold(AO_MAX_W'(stim_q), IN_W);
  assign stim_chg  = (stim != stim_q);
  assign match     = ~(ch_out ^ {NUM_CH{gold}});
  assign all_match = &match;
  assign hold_done = all_match && (run_q == RUN_W'(HOLD - 1));
  assign cnt_to    = (cnt_q == CNT_W'(TIMEOUT));
  // A change in REPORT waits for IDLE; stim_q still holds the old value.
  assign start     = stim_chg && (state_q != REPORT);
  assign meas_ok   = (state_q == MEAS) && !stim_chg;
  // HOLD completion beats timeout; abort beats both via meas_ok.
  assign to_fire   = meas_ok && cnt_to && !hold_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (stim_chg) state_d = MEAS;
      MEAS:    if (stim_chg)             state_d = MEAS;
               else if (hold_done || cnt_to) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy       = (state_q == MEAS);
    meas_valid = (state_q == REPORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stim_q  <= stim;
      cnt_q   <= '0;
      run_q   <= '0;
      abort_q <= '0;
    end else begin
      if (start) begin
        stim_q <= stim;
        cnt_q  <= '0;
        run_q  <= '0;
      end else if (state_q == MEAS) begin
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        run_q <= all_match ? run_q + RUN_W'(1) : '0;
      end
      if ((state_q == MEAS) && stim_chg && (abort_q != '1))
        abort_q <= abort_q + CNT_W'(1);
    end
  end

  assign abort_cnt = abort_q;
  assign settle    = settle_w;

`ifdef AO_SETTLE_DELTA_EN
  logic [NUM_CH-1:0][CNT_W-1:0] settle_nxt, delta_q;

  // Built from next-state settle values so delta lines up with meas_valid.
  always_ff @(posedge clk) begin
    if (rst) delta_q <= '0;
    else
      for (int i = 0; i < NUM_CH; i++)
        delta_q[i] <= (settle_nxt[i] >= settle_nxt[0]) ? settle_nxt[i] - settle_nxt[0]
                                                        : settle_nxt[0] - settle_nxt[i];
  end
  assign delta = delta_q;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ao_settle_chan #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_chan (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .meas_i       (meas_ok),
      .match_i      (match[i]),
      .timeout_i    (to_fire),
      .cnt_i        (cnt_q),
`ifdef AO_SETTLE_DELTA_EN
      .settle_nxt_o (settle_nxt[i]),
`endif
      .settle_o     (settle_w[i]),
      .timeout_err_o(timeout_err[i]),
      .glitch_err_o (glitch_err[i])
    );
  end

endmodule

// File: tb/tb_ao_settle_monitor.sv
module tb_ao_settle_monitor;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                    clk, rst;
  logic [2:0]              stim;
  logic [NUM_CH-1:0]       ch_out;
  logic                    busy, meas_valid;
  logic [NUM_CH*CNT_W-1:0] settle;
  logic [NUM_CH-1:0]       timeout_err, glitch_err;
  logic [CNT_W-1:0]        abort_cnt;
`ifdef AO_SETTLE_DELTA_EN
  logic [NUM_CH*CNT_W-1:0] delta;
`endif

  ao_settle_monitor dut (
    .clk(clk), .rst(rst), .stim(stim), .ch_out(ch_out),
    .busy(busy), .meas_valid(meas_valid), .settle(settle),
    .timeout_err(timeout_err), .glitch_err(glitch_err), .abort_cnt(abort_cnt)
`ifdef AO_SETTLE_DELTA_EN
    , .delta(delta)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic tb_gold(input logic [2:0] s);
    return (s[2] & s[1]) | s[0];
  endfunction

  // Units under test: delayed copies of the AND-OR output.
  int         dly0, dly1, age;
  logic       tie1, glt0;
  logic [2:0] cur_s, old_s;
  logic       gn, go;

  always @(posedge clk) begin
    if (rst) begin
      cur_s <= stim; old_s <= stim; age <= 1000;
    end else if (stim != cur_s) begin
      old_s <= cur_s; cur_s <= stim; age <= 0;
    end else if (age < 1000) age <= age + 1;
  end

  always_comb begin
    gn = tb_gold(cur_s);
    go = tb_gold(old_s);
    ch_out[0] = glt0 ? (((age == 1) || (age >= 5)) ? gn : ~gn) : ((age >= dly0) ? gn : go);
    ch_out[1] = tie1 ? 1'b0 : ((age >= dly1) ? gn : go);
  end

  typedef struct {
    int         s0;
    int         s1;
    logic [1:0] to;
    logic [1:0] gl;
    int         ab;
    longint     due;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0;
  logic [1:0] exp_to = '0, exp_gl = '0;
  int         exp_ab = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d @cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  // One negedge; any meas_valid is matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (meas_valid) begin
      if (sb.size() == 0) chk("unexp_pulse", 1, 0);
      else begin
        e = sb.pop_front();
        chk("lat",      cyc, e.due);
        chk("busy_rpt", busy, 0);
        chk("settle0",  settle[CNT_W-1:0], e.s0);
        chk("settle1",  settle[2*CNT_W-1:CNT_W], e.s1);
        chk("to_err",   timeout_err, e.to);
        chk("gl_err",   glitch_err, e.gl);
        chk("abort",    abort_cnt, e.ab);
`ifdef AO_SETTLE_DELTA_EN
        chk("delta0",   delta[CNT_W-1:0], 0);
        chk("delta1",   delta[2*CNT_W-1:CNT_W], (e.s1 > e.s0) ? e.s1 - e.s0 : e.s0 - e.s1);
`endif
      end
    end
  endtask

  // Drive a stimulus change, queue its expected report, wait for it.
  task automatic meas(input logic [2:0] st, input int s0, input int s1, input int lat);
    exp_t e;
    int   n;
    e.s0 = s0; e.s1 = s1; e.to = exp_to; e.gl = exp_gl; e.ab = exp_ab;
    e.due = cyc + lat;
    sb.push_back(e);
    stim = st;
    tick();
    chk("busy", busy, 1);
    n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    if (sb.size() != 0) begin
      chk("no_report", sb.size(), 0);
      sb.delete();
    end
    repeat (6) tick();  // a second pulse would show up here
  endtask

  initial begin
    rst = 1'b1; stim = 3'b000; dly0 = 3; dly1 = 2; tie1 = 1'b0; glt0 = 1'b0;
    repeat (3) tick();
    chk("rst_busy",   busy, 0);
    chk("rst_valid",  meas_valid, 0);
    chk("rst_settle", settle, 0);
    chk("rst_to",     timeout_err, 0);
    chk("rst_gl",     glitch_err, 0);
    chk("rst_abort",  abort_cnt, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 0);

    // ch0 3 cycles, ch1 2 cycles
    meas(3'b001, 3, 2, 8);
    meas(3'b010, 3, 2, 8);
    // ch0 4, ch1 5
    dly0 = 4; dly1 = 5;
    meas(3'b110, 4, 5, 10);
    meas(3'b000, 4, 5, 10);
    // ch1 stuck at 0: timeout
    tie1 = 1'b1; dly0 = 2;
    exp_to = 2'b10;
    meas(3'b001, 2, 63, 65);
    // ch0 glitch: match at 1, lose at 2, settle at 5
    tie1 = 1'b0; glt0 = 1'b1; dly1 = 2;
    exp_gl = 2'b01;
    meas(3'b000, 5, 2, 10);
    glt0 = 1'b0;
    // abort at cnt 2
    dly0 = 3; dly1 = 2;
    stim = 3'b001;
    repeat (3) tick();
    exp_ab = 1;
    meas(3'b010, 3, 2, 8);
    // reset mid-measurement
    stim = 3'b111;
    repeat (3) tick();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mrst_busy",   busy, 0);
    chk("mrst_valid",  meas_valid, 0);
    chk("mrst_settle", settle, 0);
    chk("mrst_to",     timeout_err, 0);
    chk("mrst_gl",     glitch_err, 0);
    chk("mrst_abort",  abort_cnt, 0);
`ifdef AO_SETTLE_DELTA_EN
    chk("mrst_delta",  delta, 0);
`endif
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_busy", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
